// File: rtl/elixirchip_es1_spu_op_popcount.sv
// Pipelined population count. A balanced adder tree is spread over LATENCY clock-enabled
// stages. Clear/valid flags ride alongside the data and decide whether m_data loads the count.
module elixirchip_es1_spu_op_popcount #(
  parameter int LATENCY = 3,
  parameter int DATA_BITS = 8,
  parameter int COUNT_BITS = $clog2(DATA_BITS + 1),
  parameter bit [COUNT_BITS-1:0] CLEAR_DATA = '0,
  parameter bit USE_CLEAR = 1'b1,
  parameter bit USE_VALID = 1'b1,
  parameter DEVICE = "RTL",
  parameter SIMULATION = "false",
  parameter DEBUG = "false"
) (
  input  logic                  reset,
  input  logic                  clk,
  input  logic                  cke,
  input  logic [DATA_BITS-1:0]  s_data,
  input  logic                  s_clear,
  input  logic                  s_valid,
  output logic [COUNT_BITS-1:0] m_data
);

  // The tree has LVLS adder levels. Level 0 is the raw operand bits.
  localparam int LVLS = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 0;
  localparam int FLAG_DEPTH = LATENCY - 1;

  // Every node below the root sums at most 2**k bits. The root holds the full count.
  function automatic int level_width(input int k);
    return (k == LVLS) ? COUNT_BITS : k + 1;
  endfunction

  function automatic int level_nodes(input int k);
    return (DATA_BITS + (1 << k) - 1) >> k;
  endfunction

  // Count the pipeline cuts that land after level k. There are LATENCY-1 cuts, and each
  // cut s is placed at level (s*LVLS)/LATENCY so the levels are shared out evenly.
  function automatic int regs_at(input int k);
    int c;
    c = 0;
    for (int s = 1; s < LATENCY; s++) begin
      if ((s * LVLS) / LATENCY == k) c++;
    end
    return c;
  endfunction

  logic clear_in;
  logic valid_in;
  logic clear_out;
  logic valid_out;
  logic [COUNT_BITS-1:0] count;
  logic unused_ok;

  assign clear_in = USE_CLEAR ? s_clear : 1'b0;
  assign valid_in = USE_VALID ? s_valid : 1'b1;
  assign unused_ok = &{1'b0, s_clear, s_valid, DEVICE, SIMULATION, DEBUG};

  for (genvar k = 0; k <= LVLS; k++) begin : gen_lvl
    localparam int N = level_nodes(k);
    localparam int W = level_width(k);
    localparam int R = regs_at(k);

    logic [N*W-1:0] comb;
    logic [N*W-1:0] out;

    if (k == 0) begin : gen_leaf
      assign comb = s_data;
    end else begin : gen_add
      localparam int NP = level_nodes(k - 1);
      localparam int WP = level_width(k - 1);
      for (genvar i = 0; i < N; i++) begin : gen_node
        if (2 * i + 1 < NP) begin : gen_pair
          assign comb[i*W +: W] = W'(gen_lvl[k-1].out[(2*i)*WP +: WP])
                                + W'(gen_lvl[k-1].out[(2*i+1)*WP +: WP]);
        end else begin : gen_pass
          assign comb[i*W +: W] = W'(gen_lvl[k-1].out[(2*i)*WP +: WP]);
        end
      end
    end

    // Intermediate data stages carry no reset. Their flags are cleared instead.
    if (R > 0) begin : gen_regs
      logic [N*W-1:0] stg [R];
      always_ff @(posedge clk) begin
        if (cke) begin
          stg[0] <= comb;
          for (int r = 1; r < R; r++) stg[r] <= stg[r-1];
        end
      end
      assign out = stg[R-1];
    end else begin : gen_wire
      assign out = comb;
    end
  end

  assign count = gen_lvl[LVLS].out;

  if (FLAG_DEPTH > 0) begin : gen_flags
    logic [FLAG_DEPTH-1:0] clear_sr;
    logic [FLAG_DEPTH-1:0] valid_sr;
    always_ff @(posedge clk) begin
      if (reset) begin
        clear_sr <= '0;
        valid_sr <= '0;
      end else if (cke) begin
        clear_sr[0] <= clear_in;
        valid_sr[0] <= valid_in;
        for (int j = 1; j < FLAG_DEPTH; j++) begin
          clear_sr[j] <= clear_sr[j-1];
          valid_sr[j] <= valid_sr[j-1];
        end
      end
    end
    assign clear_out = clear_sr[FLAG_DEPTH-1];
    assign valid_out = valid_sr[FLAG_DEPTH-1];
  end else begin : gen_noflags
    assign clear_out = clear_in;
    assign valid_out = valid_in;
  end

  // Output stage. Clear has priority over valid. With neither flag set, m_data holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_data <= CLEAR_DATA;
    end else if (cke) begin
      if (clear_out) m_data <= CLEAR_DATA;
      else if (valid_out) m_data <= count;
    end
  end

endmodule

// File: tb/tb_elixirchip_es1_spu_op_popcount.sv
// Bench for the popcount pipeline. Six parameter variants share one stimulus stream.
// A directed table targets the default build, and a slot-queue model checks all builds every cycle.
module tb_elixirchip_es1_spu_op_popcount;

  localparam int NI = 6;
  localparam int LAT_P [NI] = '{3, 4, 1, 2, 3, 4};
  localparam int DB_P  [NI] = '{8, 64, 1, 13, 8, 3};
  localparam int CLR_P [NI] = '{5, 0, 1, 9, 5, 2};
  localparam int UC_P  [NI] = '{1, 1, 1, 1, 0, 1};
  localparam int UV_P  [NI] = '{1, 1, 1, 1, 0, 1};

  // ---------------- clock / reset / DUTs ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cke = 1'b0;
  logic s_clear = 1'b0;
  logic s_valid = 1'b0;
  logic [63:0] data = '0;

  logic [3:0] m0;
  logic [6:0] m1;
  logic [0:0] m2;
  logic [3:0] m3;
  logic [3:0] m4;
  logic [1:0] m5;

  always #5 clk = ~clk;

  elixirchip_es1_spu_op_popcount #(.LATENCY(3), .DATA_BITS(8), .CLEAR_DATA(4'd5)) dut0 (
    .reset(reset), .clk(clk), .cke(cke), .s_data(data[7:0]),
    .s_clear(s_clear), .s_valid(s_valid), .m_data(m0));
  elixirchip_es1_spu_op_popcount #(.LATENCY(4), .DATA_BITS(64), .CLEAR_DATA(7'd0)) dut1 (
    .reset(reset), .clk(clk), .cke(cke), .s_data(data),
    .s_clear(s_clear), .s_valid(s_valid), .m_data(m1));
  elixirchip_es1_spu_op_popcount #(.LATENCY(1), .DATA_BITS(1), .CLEAR_DATA(1'b1)) dut2 (
    .reset(reset), .clk(clk), .cke(cke), .s_data(data[0:0]),
    .s_clear(s_clear), .s_valid(s_valid), .m_data(m2));
  elixirchip_es1_spu_op_popcount #(.LATENCY(2), .DATA_BITS(13), .CLEAR_DATA(4'd9)) dut3 (
    .reset(reset), .clk(clk), .cke(cke), .s_data(data[12:0]),
    .s_clear(s_clear), .s_valid(s_valid), .m_data(m3));
  elixirchip_es1_spu_op_popcount #(.LATENCY(3), .DATA_BITS(8), .CLEAR_DATA(4'd5),
    .USE_CLEAR(1'b0), .USE_VALID(1'b0)) dut4 (
    .reset(reset), .clk(clk), .cke(cke), .s_data(data[7:0]),
    .s_clear(s_clear), .s_valid(s_valid), .m_data(m4));
  elixirchip_es1_spu_op_popcount #(.LATENCY(4), .DATA_BITS(3), .CLEAR_DATA(2'd2)) dut5 (
    .reset(reset), .clk(clk), .cke(cke), .s_data(data[2:0]),
    .s_clear(s_clear), .s_valid(s_valid), .m_data(m5));

  // ---------------- scoreboard / reference model ----------------
  typedef struct { bit c; bit v; int n; } slot_t;

  int tests = 0;
  int fails = 0;
  bit model_ok = 1'b0;
  int model_m [NI];
  slot_t model_q [NI][$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Each accepted slot waits in a per-build queue. It retires on the LATENCY-th accepted
  // edge counted from the edge that sampled it. Reset throws away every waiting slot.
  task automatic model_edge();
    logic [63:0] msk;
    slot_t s;
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        model_q[i].delete();
        model_m[i] = CLR_P[i];
      end else if (cke) begin
        msk = (DB_P[i] == 64) ? '1 : ((64'd1 << DB_P[i]) - 64'd1);
        s.c = (UC_P[i] != 0) ? s_clear : 1'b0;
        s.v = (UV_P[i] != 0) ? s_valid : 1'b1;
        s.n = $countones(data & msk);
        model_q[i].push_back(s);
        if (model_q[i].size() == LAT_P[i]) begin
          s = model_q[i].pop_front();
          if (s.c) model_m[i] = CLR_P[i];
          else if (s.v) model_m[i] = s.n;
        end
      end
    end
    if (reset) model_ok = 1'b1;
  endtask

  task automatic check_models();
    logic [31:0] act [NI];
    act[0] = 32'(m0); act[1] = 32'(m1); act[2] = 32'(m2);
    act[3] = 32'(m3); act[4] = 32'(m4); act[5] = 32'(m5);
    if (model_ok) begin
      for (int i = 0; i < NI; i++) check($sformatf("model_dut%0d", i), act[i], model_m[i]);
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_models();
  endtask

  task automatic drive(input bit r, input bit ce, input bit c, input bit v, input logic [63:0] d);
    reset = r; cke = ce; s_clear = c; s_valid = v; data = d;
  endtask

  typedef struct { bit rst; bit ce; bit clr; bit vld; logic [7:0] d; int exp; } vec_t;
  vec_t tbl [$];

  function automatic void add(input bit r, input bit ce, input bit c, input bit v,
                              input logic [7:0] d, input int e);
    vec_t t;
    t.rst = r; t.ce = ce; t.clr = c; t.vld = v; t.d = d; t.exp = e;
    tbl.push_back(t);
  endfunction

  initial begin
    // Stream 00,ff,5a,01,80,07, then idle slots.
    add(0,1,0,1,8'h00,5); add(0,1,0,1,8'hff,5); add(0,1,0,1,8'h5a,0);
    add(0,1,0,1,8'h01,8); add(0,1,0,1,8'h80,4); add(0,1,0,1,8'h07,1);
    add(0,1,0,0,8'h00,1); add(0,1,0,0,8'h00,3);
    // The same stream with a two-cycle cke gap after ff. The output freezes at 3.
    add(0,1,0,1,8'h00,3); add(0,1,0,1,8'hff,3); add(0,0,0,1,8'haa,3); add(0,0,0,1,8'haa,3);
    add(0,1,0,1,8'h5a,0); add(0,1,0,1,8'h01,8); add(0,1,0,1,8'h80,4);
    add(0,1,0,0,8'h00,1); add(0,1,0,0,8'h00,1);
    // Clear without valid, then a non-valid slot, then valid 03.
    add(0,1,1,0,8'hff,1); add(0,1,0,0,8'h0f,1); add(0,1,0,1,8'h03,5);
    add(0,1,0,0,8'h00,5); add(0,1,0,0,8'h00,2); add(0,1,0,0,8'h00,2);
    // Reset pulses while slots are in flight.
    add(0,1,0,1,8'hff,2); add(0,1,0,1,8'h0f,2); add(0,1,0,1,8'h07,8);
    add(1,1,0,1,8'h01,5); add(0,1,0,1,8'h03,5); add(0,1,0,0,8'h00,5);
    add(0,1,0,0,8'h00,2); add(0,1,0,0,8'h00,2);
    // Reset overrides cke=0. Clear wins over valid.
    add(1,0,0,0,8'h00,5); add(0,0,0,1,8'hff,5); add(0,1,1,1,8'hff,5);
    add(0,1,0,1,8'hff,5); add(0,1,0,1,8'h01,5); add(0,1,0,0,8'h00,8);
    add(0,1,0,0,8'h00,1); add(0,1,0,0,8'h00,1);

    drive(1, 0, 0, 0, '0);
    tick(); tick();
    check("reset_state", 32'(m0), 32'd5);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].ce, tbl[i].clr, tbl[i].vld, {56'd0, tbl[i].d});
      tick();
      check($sformatf("vec%0d", i), 32'(m0), tbl[i].exp);
    end

    // With USE_CLEAR/USE_VALID off, both flags are ignored and 0x0f yields 4.
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 0, 64'h0f);
      tick();
    end
    check("noflags_0f", 32'(m4), 32'd4);
    check("clear_0f", 32'(m0), 32'd5);

    // The 64-bit all-ones operand counts to 64.
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 1, '1);
      tick();
    end
    check("ones64", 32'(m1), 32'd64);

    // Randomized slots across all builds
    for (int i = 0; i < 1000; i++) begin
      logic [63:0] d;
      case ($urandom_range(0, 7))
        0: d = '1;
        1: d = '0;
        default: d = {$urandom(), $urandom()};
      endcase
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1, d);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
